dwc_parallelwindow_gather: RTL

Inverse of the parallel-window width converter. It gathers a stream of narrow SIMD×PE activation beats, ordered NF-outer and SF-inner, back into one full KERNEL_PROD×CHANNELS window word. It sits after a folded compute stage, or in loopback after the scatter DWC, wherever a downstream block needs the whole window in parallel. AXI-Stream in and out, one clock domain.

---
 rtl/dwc_parallelwindow_gather.sv | 110 +++++++++++
 1 files changed

// File: rtl/dwc_parallelwindow_gather.sv
// dwc_parallelwindow_gather: gathers SIMDxPE beats into one KERNEL_PROD x CHANNELS window; DWC_GATHER_DOUBLE_BUF_EN selects ping-pong buffering
module dwc_parallelwindow_gather #(
   parameter int SIMD             = 5,
   parameter int PE               = 2,
   parameter int CHANNELS         = 10,
   parameter int KERNEL_PROD      = 25,
   parameter int ACTIVATION_WIDTH = 4,
   parameter int IN_WIDTH         = ACTIVATION_WIDTH*PE*SIMD,
   parameter int OUT_WIDTH        = ACTIVATION_WIDTH*KERNEL_PROD*CHANNELS
)(
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
   input  logic                 s_axis_input_tvalid,
   output logic                 s_axis_input_tready,
   output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
   output logic                 m_axis_output_tvalid,
   input  logic                 m_axis_output_tready
);
   localparam int SF  = KERNEL_PROD/SIMD;
   localparam int NF  = CHANNELS/PE;
   localparam int SW  = SF > 1 ? $clog2(SF) : 1;
   localparam int NW  = NF > 1 ? $clog2(NF) : 1;
   localparam int IIW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
   localparam int OIW = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;
   if (IN_WIDTH != ACTIVATION_WIDTH*PE*SIMD) begin : g_in_chk
      $error("IN_WIDTH must equal ACTIVATION_WIDTH*PE*SIMD");
   end
   if (OUT_WIDTH != ACTIVATION_WIDTH*KERNEL_PROD*CHANNELS) begin : g_out_chk
      $error("OUT_WIDTH must equal ACTIVATION_WIDTH*KERNEL_PROD*CHANNELS");
   end
   logic [SW-1:0] sf;
   logic [NW-1:0] nf;
   logic          in_hs, sf_last, last;
   assign in_hs   = s_axis_input_tvalid & s_axis_input_tready;
   assign sf_last = sf == SW'(SF-1);
   assign last    = in_hs & sf_last & (nf == NW'(NF-1));
   // Writes the current beat into its SIMDxPE slice of a window, leaving the rest untouched
   function automatic logic [OUT_WIDTH-1:0] place(input logic [OUT_WIDTH-1:0] w, input logic [IN_WIDTH-1:0] d,
                                                  input logic [SW-1:0] s, input logic [NW-1:0] n);
      place = w;
      for (int k = 0; k < SIMD; k++)
         for (int l = 0; l < PE; l++)
            place[OIW'(((k + int'(s)*SIMD)*CHANNELS + l + int'(n)*PE)*ACTIVATION_WIDTH) +: ACTIVATION_WIDTH] =
               d[IIW'((k*PE + l)*ACTIVATION_WIDTH) +: ACTIVATION_WIDTH];
   endfunction
   // Beat position: sf inner, nf outer, advancing only on accepted beats
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         sf <= '0;
         nf <= '0;
      end else if (in_hs) begin
         sf <= sf_last ? '0 : sf + 1'b1;
         nf <= !sf_last ? nf : (nf == NW'(NF-1)) ? '0 : nf + 1'b1;
      end
`ifdef DWC_GATHER_DOUBLE_BUF_EN
   logic [OUT_WIDTH-1:0] win [2];
   logic [1:0]           full, full_nxt;
   logic                 wr_sel, rd_sel, rdy, out_hs;
   assign out_hs = m_axis_output_tvalid & m_axis_output_tready;
   // Occupancy after this cycle: a completed fill marks its buffer, a drained window frees its buffer
   always_comb begin
      full_nxt = full;
      if (last) full_nxt[wr_sel] = 1'b1;
      if (out_hs) full_nxt[rd_sel] = 1'b0;
   end
   // Ping-pong pointers and registered ready, which drops only with both buffers occupied
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         rdy    <= 1'b0;
      end else begin
         full   <= full_nxt;
         wr_sel <= wr_sel ^ last;
         rd_sel <= rd_sel ^ out_hs;
         rdy    <= ~&full_nxt;
      end
   // Window storage carries no reset; every slice is rewritten before it is presented
   always_ff @(posedge ap_clk)
      if (in_hs) win[wr_sel] <= place(win[wr_sel], s_axis_input_tdata, sf, nf);
   assign s_axis_input_tready  = rdy;
   assign m_axis_output_tvalid = full[rd_sel];
   assign m_axis_output_tdata  = win[rd_sel];
`else
   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
   state_t               state, state_nxt;
   logic [OUT_WIDTH-1:0] win;
   // State register; IDLE holds ready low until the first cycle after reset
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) state <= IDLE;
      else state <= state_nxt;
   // Next state: fill until the last beat, present until the window is taken
   always_comb begin
      state_nxt = (state == IDLE) ? FILL :
                  (state == FILL && last) ? FULL :
                  (state == FULL && m_axis_output_tready) ? FILL : state;
   end
   // Handshake outputs decode straight from the state register
   always_comb begin
      s_axis_input_tready  = state == FILL;
      m_axis_output_tvalid = state == FULL;
   end
   // Window storage carries no reset; every slice is rewritten before it is presented
   always_ff @(posedge ap_clk)
      if (in_hs) win <= place(win, s_axis_input_tdata, sf, nf);
   assign m_axis_output_tdata = win;
`endif
endmodule
